// File: rtl/boot_loader_master.sv
// Boot-load master: pulls CODE_SIZE words from a valid/ready source and writes them
// into the instruction cache through the CPU boot port at addresses 0..CODE_SIZE-1.
module boot_loader_master #(
    parameter int CODE_SIZE = 45,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              boot_up,
    output logic              boot_web,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [DATA_W-1:0] boot_datai,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CODE_SIZE - 1);
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_LOAD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_boot_up;
    logic              w_boot_up_nxt;
    logic              r_boot_web;
    logic              w_boot_web_nxt;
    logic [ADDR_W-1:0] r_boot_addr;
    logic [ADDR_W-1:0] w_boot_addr_nxt;
    logic [DATA_W-1:0] r_boot_datai;
    logic [DATA_W-1:0] w_boot_datai_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_hs;

    assign src_ready  = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign boot_up    = r_boot_up;
    assign boot_web   = r_boot_web;
    assign boot_addr  = r_boot_addr;
    assign boot_datai = r_boot_datai;
    assign done       = r_done;

    // Next-state and next-output logic; every exit to IDLE restores the idle bus values.
    always_comb begin
        w_hs             = src_valid & (r_state == S_LOAD);
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_boot_up_nxt    = r_boot_up;
        w_boot_web_nxt   = 1'b1;
        w_boot_addr_nxt  = r_boot_addr;
        w_boot_datai_nxt = r_boot_datai;
        w_done_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt        = '0;
                w_boot_addr_nxt  = '0;
                w_boot_datai_nxt = '0;
                if (start && !abort) begin
                    w_state_nxt   = S_ARM;
                    w_boot_up_nxt = 1'b1;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_boot_up_nxt = 1'b0;
                end
            end
            S_ARM: begin
                if (abort) begin
                    w_state_nxt      = S_IDLE;
                    w_boot_up_nxt    = 1'b0;
                    w_boot_addr_nxt  = '0;
                    w_boot_datai_nxt = '0;
                    w_cnt_nxt        = '0;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    // A word accepted in this cycle is dropped, not written.
                    w_state_nxt      = S_IDLE;
                    w_boot_up_nxt    = 1'b0;
                    w_boot_addr_nxt  = '0;
                    w_boot_datai_nxt = '0;
                    w_cnt_nxt        = '0;
                end else if (w_hs) begin
                    w_boot_web_nxt   = 1'b0;
                    w_boot_addr_nxt  = r_cnt;
                    w_boot_datai_nxt = src_data;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end else begin
                    w_boot_web_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                w_state_nxt      = S_IDLE;
                w_boot_up_nxt    = 1'b0;
                w_boot_addr_nxt  = '0;
                w_boot_datai_nxt = '0;
                w_cnt_nxt        = '0;
                w_done_nxt       = ~abort;
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_boot_up_nxt    = 1'b0;
                w_boot_addr_nxt  = '0;
                w_boot_datai_nxt = '0;
                w_cnt_nxt        = '0;
            end
        endcase
    end

    // State, counter and registered boot-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_boot_up    <= 1'b0;
            r_boot_web   <= 1'b1;
            r_boot_addr  <= '0;
            r_boot_datai <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_boot_up    <= w_boot_up_nxt;
            r_boot_web   <= w_boot_web_nxt;
            r_boot_addr  <= w_boot_addr_nxt;
            r_boot_datai <= w_boot_datai_nxt;
            r_done       <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_boot_loader_master.sv
// Scoreboard bench for boot_loader_master: accepted words are queued as expected
// writes; an independent monitor pops them whenever the boot port writes.
module tb_boot_loader_master;
    localparam int N  = 45;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready, boot_up, boot_web, busy, done;
    logic [AW-1:0] boot_addr;
    logic [DW-1:0] boot_datai;

    logic          s1_start, s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_ready, s1_up, s1_web, s1_busy, s1_done;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_datai;

    always #5 clk = ~clk;

    boot_loader_master #(.CODE_SIZE(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .boot_up(boot_up), .boot_web(boot_web), .boot_addr(boot_addr),
        .boot_datai(boot_datai), .busy(busy), .done(done)
    );

    boot_loader_master #(.CODE_SIZE(1), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .abort(1'b0),
        .src_valid(s1_valid), .src_data(s1_data), .src_ready(s1_ready),
        .boot_up(s1_up), .boot_web(s1_web), .boot_addr(s1_addr),
        .boot_datai(s1_datai), .busy(s1_busy), .done(s1_done)
    );

    int            checks = 0;
    int            errors = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    bit            wrote = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every boot-port write must match the oldest accepted word.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (boot_web === 1'b0) begin
                chk("write_boot_up", 64'(boot_up), 64'(1'b1));
                chk("write_expected", 64'(exp_addr_q.size() != 0), 64'(1'b1));
                if (exp_addr_q.size() != 0) begin
                    chk("write_addr", 64'(boot_addr), 64'(exp_addr_q.pop_front()));
                    chk("write_data", 64'(boot_datai), 64'(exp_data_q.pop_front()));
                end
                wr_cnt++;
                wrote = 1'b1;
                last_addr = boot_addr;
            end else if (boot_up === 1'b1 && wrote) begin
                chk("addr_hold", 64'(boot_addr), 64'(last_addr));
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("done_all_written", 64'(wr_cnt), 64'(N));
                chk("done_queue_empty", 64'(exp_addr_q.size()), 64'(0));
            end
        end
    end

    // mode 0: src_valid always 1, 1: toggled, 2: random.
    task automatic run_load(input int mode, input int abort_at, input int start_at,
                            input int rst_at, input bit timing);
        int  acc = 0;
        int  dc0 = done_cnt;
        bit  ended = 1'b0;
        bit  was_rst = 1'b0;
        wr_cnt = 0;
        wrote  = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        abort     = 1'b0;
        src_valid = (mode == 0);
        src_data  = $urandom;
        for (int c = 1; c < 400 && !ended; c++) begin
            @(negedge clk);
            if (timing) begin
                chk("t_boot_up", 64'(boot_up), 64'(c >= 1 && c <= N + 2));
                chk("t_web", 64'(boot_web), 64'(!(c >= 3 && c <= N + 2)));
                chk("t_ready", 64'(src_ready), 64'(c >= 2 && c <= N + 1));
                chk("t_busy", 64'(busy), 64'(c <= N + 2));
                chk("t_done", 64'(done), 64'(c == N + 3));
                if (c >= 3 && c <= N + 2) chk("t_addr", 64'(boot_addr), 64'(c - 3));
                else chk("t_addr_idle", 64'(boot_addr), 64'(0));
            end
            if (busy !== 1'b1) begin
                ended = 1'b1;
            end else if (c == rst_at) begin
                src_valid = 1'b0;
                @(posedge clk);
                #3 rst = 1'b1;
                #1;
                chk("rst_boot_up", 64'(boot_up), 64'(0));
                chk("rst_web", 64'(boot_web), 64'(1));
                chk("rst_ready", 64'(src_ready), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_addr", 64'(boot_addr), 64'(0));
                exp_addr_q.delete();
                exp_data_q.delete();
                @(negedge clk);
                #1 rst = 1'b0;
                ended   = 1'b1;
                was_rst = 1'b1;
            end else begin
                start     = (c == start_at);
                src_valid = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(0, 1));
                src_data  = $urandom;
                abort     = (abort_at >= 0 && acc == abort_at);
                #1;
                if (src_valid && src_ready) begin
                    if (!abort) begin
                        exp_addr_q.push_back(AW'(acc));
                        exp_data_q.push_back(src_data);
                    end
                    acc++;
                end
            end
        end
        start     = 1'b0;
        abort     = 1'b0;
        src_valid = 1'b0;
        chk("load_terminated", 64'(ended), 64'(1));
        if (was_rst) begin
            chk("rst_no_done", 64'(done_cnt), 64'(dc0));
        end else if (abort_at >= 0) begin
            chk("abort_boot_up", 64'(boot_up), 64'(0));
            chk("abort_web", 64'(boot_web), 64'(1));
            chk("abort_addr", 64'(boot_addr), 64'(0));
            chk("abort_writes", 64'(wr_cnt), 64'(abort_at));
            chk("abort_queue", 64'(exp_addr_q.size()), 64'(0));
            repeat (3) @(negedge clk);
            chk("abort_no_done", 64'(done_cnt), 64'(dc0));
        end else begin
            @(negedge clk);
            chk("done_pulse", 64'(done_cnt), 64'(dc0 + 1));
            chk("done_one_cycle", 64'(done), 64'(0));
        end
    endtask

    initial begin
        logic [DW-1:0] d1;
        rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = '0;
        s1_start = 1'b0; s1_valid = 1'b0; s1_data = '0;
        #3;
        chk("reset_boot_up", 64'(boot_up), 64'(0));
        chk("reset_web", 64'(boot_web), 64'(1));
        chk("reset_addr", 64'(boot_addr), 64'(0));
        chk("reset_datai", 64'(boot_datai), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ready", 64'(src_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_load(0, -1, -1, -1, 1'b1);
        run_load(1, -1, -1, -1, 1'b0);
        run_load(0, 10, -1, -1, 1'b0);
        run_load(2, -1, -1, -1, 1'b0);
        run_load(2, -1, 20, -1, 1'b0);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'(0));
        chk("start_abort_up", 64'(boot_up), 64'(0));

        run_load(2, -1, -1, 30, 1'b0);
        run_load(0, -1, -1, -1, 1'b0);

        @(negedge clk);
        s1_start = 1'b1; s1_valid = 1'b1; s1_data = $urandom; d1 = s1_data;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            s1_start = 1'b0;
            chk("s1_up", 64'(s1_up), 64'(c >= 1 && c <= 3));
            chk("s1_web", 64'(s1_web), 64'(c != 3));
            chk("s1_ready", 64'(s1_ready), 64'(c == 2));
            chk("s1_busy", 64'(s1_busy), 64'(c <= 3));
            chk("s1_done", 64'(s1_done), 64'(c == 4));
            if (c == 3) begin
                chk("s1_addr", 64'(s1_addr), 64'(0));
                chk("s1_data", 64'(s1_datai), 64'(d1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
